ram_read_convkernal_2: RTL and testbench



---
 rtl/ram_read_convkernal_2_pkg.sv | 23 ++
 rtl/conv2_kernel_rom.sv | 22 ++
 rtl/ram_read_convkernal_2.sv | 179 +++++++++++++++++
 tb/tb_ram_read_convkernal_2.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_read_convkernal_2_pkg.sv
// Purpose : shared constants, FSM state type and ROM contents function for the conv2 kernel fetcher.
// Latency : n/a (package).
// Backpressure: n/a (package).
package ram_read_convkernal_2_pkg;

    localparam int KSIZE  = 25;   // 5x5 kernel, row-major
    localparam int ADDR_W = 15;   // 32768-deep weight ROM
    localparam int IDX_W  = 6;    // count / num / channel width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Behavioural weight image: a fixed scrambled bit pattern over the address.
    // The vendor memory generator substitutes the real INIT_FILE image.
    function automatic logic rom_pattern(input logic [ADDR_W-1:0] a);
        return (^(a & 15'h2A5B)) ^ (a[2] & a[6]);
    endfunction

endpackage

// File: rtl/conv2_kernel_rom.sv
// Purpose : 1-bit x 32768 synchronous weight ROM for the conv2 kernel bank.
// Latency : 1 cycle, data_o reflects addr_i sampled at the previous rising edge.
// Backpressure: none, a new address is accepted every cycle.
// Ports   : clk_i clock; addr_i word address; data_o registered weight bit.
module conv2_kernel_rom
    import ram_read_convkernal_2_pkg::*;
#(
    parameter INIT_FILE = "conv2_kernel.coe"
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              data_o
);

    // An empty image name yields an all-zero ROM.
    localparam bit BLANK = (INIT_FILE == '0);

    always_ff @(posedge clk_i) begin
        data_o <= BLANK ? 1'b0 : rom_pattern(addr_i);
    end

endmodule

// File: rtl/ram_read_convkernal_2.sv
// Purpose : fetches 25-bit binarised 5x5 kernels from the weight ROM, channel by channel, kernel by kernel.
// Latency : ok rises 27 edges after en is sampled in IDLE; 28 cycles per kernel with en held high.
// Backpressure: en is a level request sampled only in IDLE; once started a load always completes.
// Ports   : clk/rst (async, active-high); en request; ok/step_stop strobes; stop sticky bank-done;
//           count/num/channel/addra indices; kernal_data_0..24 kernel weights (index = row*5+col).
module ram_read_convkernal_2
    import ram_read_convkernal_2_pkg::*;
#(
    parameter int IN_CH     = 32,
    parameter int OUT_CH    = 32,
    parameter     INIT_FILE = "conv2_kernel.coe"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              ok,
    output logic              stop,
    output logic              step_stop,
    output logic [IDX_W-1:0]  count,
    output logic [IDX_W-1:0]  num,
    output logic [IDX_W-1:0]  channel,
    output logic [ADDR_W-1:0] addra,
    output logic kernal_data_0,  output logic kernal_data_1,  output logic kernal_data_2,
    output logic kernal_data_3,  output logic kernal_data_4,  output logic kernal_data_5,
    output logic kernal_data_6,  output logic kernal_data_7,  output logic kernal_data_8,
    output logic kernal_data_9,  output logic kernal_data_10, output logic kernal_data_11,
    output logic kernal_data_12, output logic kernal_data_13, output logic kernal_data_14,
    output logic kernal_data_15, output logic kernal_data_16, output logic kernal_data_17,
    output logic kernal_data_18, output logic kernal_data_19, output logic kernal_data_20,
    output logic kernal_data_21, output logic kernal_data_22, output logic kernal_data_23,
    output logic kernal_data_24
);

    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(IN_CH - 1);
    localparam logic [IDX_W-1:0] LAST_NUM = IDX_W'(OUT_CH - 1);
    localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(KSIZE - 1);
    localparam logic [4:0]       LAST_IDX = 5'(KSIZE - 1);

    state_t              state_q;
    logic [IDX_W-1:0]    count_q, num_q, chan_q;
    logic [ADDR_W-1:0]   addra_q;
    logic                ok_q, step_q, stop_q;
    // Two-stage tag pipeline following each issued address through the ROM:
    // iss_* = address issued at the last edge, cap_* = ROM output now valid.
    logic                iss_vld_q, cap_vld_q;
    logic [4:0]          iss_idx_q, cap_idx_q;
    logic [KSIZE-1:0]    buf_q, buf_d;
    logic [KSIZE-1:0]    kdat_q;
    logic                rom_bit;
    logic                last_chan, last_kernel;

    conv2_kernel_rom #(
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk_i  (clk),
        .addr_i (addra_q),
        .data_o (rom_bit)
    );

    assign last_chan   = (chan_q == LAST_CH);
    assign last_kernel = last_chan && (num_q == LAST_NUM);

    // Buffer with this cycle's capture merged in, so the final bit (element 24)
    // lands in the same edge that publishes the kernel.
    always_comb begin
        buf_d = buf_q;
        if (cap_vld_q) begin
            buf_d[cap_idx_q] = rom_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            num_q     <= '0;
            chan_q    <= '0;
            addra_q   <= '0;
            ok_q      <= 1'b0;
            step_q    <= 1'b0;
            stop_q    <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_idx_q <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            buf_q     <= '0;
            kdat_q    <= '0;
        end else begin
            ok_q      <= 1'b0;
            step_q    <= 1'b0;
            iss_vld_q <= 1'b0;
            cap_vld_q <= iss_vld_q;
            cap_idx_q <= iss_idx_q;
            buf_q     <= buf_d;
            case (state_q)
                IDLE: begin
                    // addra already holds this kernel's base address.
                    if (en && !stop_q) begin
                        state_q   <= READ;
                        count_q   <= '0;
                        iss_vld_q <= 1'b1;
                        iss_idx_q <= '0;
                    end
                end
                READ: begin
                    count_q   <= count_q + 6'd1;
                    addra_q   <= addra_q + 15'd1;
                    iss_vld_q <= 1'b1;
                    iss_idx_q <= count_q[4:0] + 5'd1;
                    if (count_q == LAST_K - 6'd1) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap_vld_q && (cap_idx_q == LAST_IDX)) begin
                        kdat_q  <= buf_d;
                        ok_q    <= 1'b1;
                        step_q  <= last_chan;
                        if (last_kernel) begin
                            stop_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    count_q <= '0;
                    state_q <= IDLE;
                    // addra sits at base+24, so +1 is the next kernel's base.
                    // After the final kernel all indices freeze.
                    if (!last_kernel) begin
                        addra_q <= addra_q + 15'd1;
                        if (last_chan) begin
                            chan_q <= '0;
                            num_q  <= num_q + 6'd1;
                        end else begin
                            chan_q <= chan_q + 6'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ok        = ok_q;
    assign stop      = stop_q;
    assign step_stop = step_q;
    assign count     = count_q;
    assign num       = num_q;
    assign channel   = chan_q;
    assign addra     = addra_q;

    assign kernal_data_0  = kdat_q[0];
    assign kernal_data_1  = kdat_q[1];
    assign kernal_data_2  = kdat_q[2];
    assign kernal_data_3  = kdat_q[3];
    assign kernal_data_4  = kdat_q[4];
    assign kernal_data_5  = kdat_q[5];
    assign kernal_data_6  = kdat_q[6];
    assign kernal_data_7  = kdat_q[7];
    assign kernal_data_8  = kdat_q[8];
    assign kernal_data_9  = kdat_q[9];
    assign kernal_data_10 = kdat_q[10];
    assign kernal_data_11 = kdat_q[11];
    assign kernal_data_12 = kdat_q[12];
    assign kernal_data_13 = kdat_q[13];
    assign kernal_data_14 = kdat_q[14];
    assign kernal_data_15 = kdat_q[15];
    assign kernal_data_16 = kdat_q[16];
    assign kernal_data_17 = kdat_q[17];
    assign kernal_data_18 = kdat_q[18];
    assign kernal_data_19 = kdat_q[19];
    assign kernal_data_20 = kdat_q[20];
    assign kernal_data_21 = kdat_q[21];
    assign kernal_data_22 = kdat_q[22];
    assign kernal_data_23 = kdat_q[23];
    assign kernal_data_24 = kdat_q[24];

endmodule

// File: tb/tb_ram_read_convkernal_2.sv
module tb_ram_read_convkernal_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, en_s;

    logic        ok, stop, step_stop;
    logic [5:0]  count, num, channel;
    logic [14:0] addra;
    logic [24:0] kd;

    logic        ok_s, stop_s, step_s;
    logic [5:0]  count_s, num_s, channel_s;
    logic [14:0] addra_s;
    logic [24:0] kd_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_read_convkernal_2 dut (
        .clk(clk), .rst(rst), .en(en),
        .ok(ok), .stop(stop), .step_stop(step_stop),
        .count(count), .num(num), .channel(channel), .addra(addra),
        .kernal_data_0(kd[0]),   .kernal_data_1(kd[1]),   .kernal_data_2(kd[2]),
        .kernal_data_3(kd[3]),   .kernal_data_4(kd[4]),   .kernal_data_5(kd[5]),
        .kernal_data_6(kd[6]),   .kernal_data_7(kd[7]),   .kernal_data_8(kd[8]),
        .kernal_data_9(kd[9]),   .kernal_data_10(kd[10]), .kernal_data_11(kd[11]),
        .kernal_data_12(kd[12]), .kernal_data_13(kd[13]), .kernal_data_14(kd[14]),
        .kernal_data_15(kd[15]), .kernal_data_16(kd[16]), .kernal_data_17(kd[17]),
        .kernal_data_18(kd[18]), .kernal_data_19(kd[19]), .kernal_data_20(kd[20]),
        .kernal_data_21(kd[21]), .kernal_data_22(kd[22]), .kernal_data_23(kd[23]),
        .kernal_data_24(kd[24])
    );

    ram_read_convkernal_2 #(.IN_CH(2), .OUT_CH(2)) dut_s (
        .clk(clk), .rst(rst), .en(en_s),
        .ok(ok_s), .stop(stop_s), .step_stop(step_s),
        .count(count_s), .num(num_s), .channel(channel_s), .addra(addra_s),
        .kernal_data_0(kd_s[0]),   .kernal_data_1(kd_s[1]),   .kernal_data_2(kd_s[2]),
        .kernal_data_3(kd_s[3]),   .kernal_data_4(kd_s[4]),   .kernal_data_5(kd_s[5]),
        .kernal_data_6(kd_s[6]),   .kernal_data_7(kd_s[7]),   .kernal_data_8(kd_s[8]),
        .kernal_data_9(kd_s[9]),   .kernal_data_10(kd_s[10]), .kernal_data_11(kd_s[11]),
        .kernal_data_12(kd_s[12]), .kernal_data_13(kd_s[13]), .kernal_data_14(kd_s[14]),
        .kernal_data_15(kd_s[15]), .kernal_data_16(kd_s[16]), .kernal_data_17(kd_s[17]),
        .kernal_data_18(kd_s[18]), .kernal_data_19(kd_s[19]), .kernal_data_20(kd_s[20]),
        .kernal_data_21(kd_s[21]), .kernal_data_22(kd_s[22]), .kernal_data_23(kd_s[23]),
        .kernal_data_24(kd_s[24])
    );

    // Weight image: parity of address bits {0,1,3,4,6,9,11,13} xor (a2 & a6).
    function automatic logic exp_bit(input int a);
        int sel[8] = '{0, 1, 3, 4, 6, 9, 11, 13};
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[sel[i]]) ones++;
        end
        return ((ones % 2) == 1) != (a[2] && a[6]);
    endfunction

    function automatic logic [24:0] exp_kernel(input int k);
        logic [24:0] r;
        for (int e = 0; e < 25; e++) r[e] = exp_bit(k * 25 + e);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for ok on the main instance; optionally checks outputs stay at 'last' meanwhile.
    task automatic wait_ok(input int budget, input bit stable, input logic [24:0] last, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (stable && ok !== 1'b1) chk("kd_stable", kd, last);
        end while (ok !== 1'b1 && n < budget);
        if (ok !== 1'b1) chk("ok_timeout", ok, 1);
    endtask

    task automatic wait_ok_s(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ok_s !== 1'b1 && n < budget);
        if (ok_s !== 1'b1) chk("ok_s_timeout", ok_s, 1);
    endtask

    initial begin
        int n;
        int seen;
        logic [14:0] hold;

        rst = 1'b1; en = 1'b0; en_s = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ok", ok, 0);
        chk("rst_stop", stop, 0);
        chk("rst_step", step_stop, 0);
        chk("rst_count", count, 0);
        chk("rst_num", num, 0);
        chk("rst_chan", channel, 0);
        chk("rst_addra", addra, 0);
        chk("rst_kd", kd, 0);
        rst = 1'b0;

        // Small bank (2x2) run to completion.
        @(negedge clk);
        en_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ok_s(40, n);
            chk("s_period", n, (k == 0) ? 27 : 28);
            chk("s_kd", kd_s, exp_kernel(k));
            chk("s_step", step_s, k % 2);
            chk("s_stop", stop_s, (k == 3) ? 1 : 0);
        end
        chk("s_addra_final", addra_s, 99);
        hold = addra_s;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (ok_s === 1'b1) seen++;
            chk("s_addra_hold", addra_s, hold);
        end
        chk("s_no_ok_after_stop", seen, 0);
        chk("s_stop_sticky", stop_s, 1);
        chk("s_num_hold", num_s, 1);
        chk("s_chan_hold", channel_s, 1);
        chk("s_count_idle", count_s, 0);
        en_s = 1'b0;

        // First kernel, en released on ok.
        en = 1'b1;
        wait_ok(40, 1'b0, '0, n);
        chk("k0_latency", n, 27);
        chk("k0_kd", kd, exp_kernel(0));
        chk("k0_step", step_stop, 0);
        en = 1'b0;
        @(negedge clk);
        chk("k0_ok_pulse", ok, 0);
        chk("k0_chan", channel, 1);
        chk("k0_num", num, 0);
        chk("k0_addra", addra, 25);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ok === 1'b1) seen++;
        end
        chk("k0_no_extra_ok", seen, 0);

        // en held high: kernels 1..31 back to back.
        en = 1'b1;
        for (int s = 1; s < 32; s++) begin
            wait_ok(40, 1'b1, exp_kernel(s - 1), n);
            chk("bb_period", n, (s == 1) ? 27 : 28);
            chk("bb_kd", kd, exp_kernel(s));
            chk("bb_step", step_stop, (s == 31) ? 1 : 0);
        end
        @(negedge clk);
        chk("wrap_num", num, 1);
        chk("wrap_chan", channel, 0);
        chk("wrap_addra", addra, 800);
        en = 1'b0;

        // Address sweep; en dropped mid-READ.
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("sweep_count", count, i);
            chk("sweep_addra", addra, 800 + i);
            if (i == 10) en = 1'b0;
        end
        wait_ok(10, 1'b1, exp_kernel(31), n);
        chk("drop_drain", n, 2);
        chk("drop_kd", kd, exp_kernel(32));
        @(negedge clk);
        chk("drop_chan", channel, 1);
        chk("drop_num", num, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ok === 1'b1) seen++;
        end
        chk("drop_no_restart", seen, 0);
        chk("drop_addra_idle", addra, 825);

        // Reset at count 12 mid-load.
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (count !== 6'd12 && n < 30);
        chk("mid_reached", count, 12);
        rst = 1'b1;
        #1;
        chk("mrst_ok", ok, 0);
        chk("mrst_stop", stop, 0);
        chk("mrst_count", count, 0);
        chk("mrst_num", num, 0);
        chk("mrst_chan", channel, 0);
        chk("mrst_addra", addra, 0);
        chk("mrst_kd", kd, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_addra", addra, 0);
        chk("restart_chan", channel, 0);
        chk("restart_count", count, 0);
        wait_ok(40, 1'b1, '0, n);
        chk("restart_latency", n, 26);
        chk("restart_kd", kd, exp_kernel(0));
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
